// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard control block.
package Pipe_Ctrl_PKG;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } haz_state_t;

  // Control strobes returned to the pipeline registers and the PC.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } haz_ctrl_t;

  // Idle: pipeline advances freely.
  localparam haz_ctrl_t CTRL_NONE     = haz_ctrl_t'(7'b000_0000);
  // Data-memory wait: hold PC through EX/MEM, drain MEM/WB with a bubble.
  localparam haz_ctrl_t CTRL_FREEZE   = haz_ctrl_t'(7'b111_1001);
  // Taken control transfer in EX: squash the two younger slots.
  localparam haz_ctrl_t CTRL_REDIRECT = haz_ctrl_t'(7'b000_0110);
  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  localparam haz_ctrl_t CTRL_LOAD_USE = haz_ctrl_t'(7'b110_0010);

  // A load in EX whose destination feeds a source of the decoding instruction.
  // rs2 is compared for every format; a spurious stall on I-type is harmless.
  function automatic logic load_use_hit(
    input logic       memread,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return memread & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step only when requested and not yet saturated.
  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Stall/flush/bubble generation for the five-stage pipeline: load-use,
// EX-stage redirects and variable-latency data-memory waits with watchdog.
module pipe_hazard_unit
  import Pipe_Ctrl_PKG::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             ex_redirect,
  input  logic             ex_mem_memread,
  input  logic             ex_mem_memwrite,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

  haz_state_t        state_q;
  haz_state_t        state_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;
  logic              timeout_q;
  logic              timeout_d;

  logic              mem_pend_s;
  logic              load_use_s;
  haz_ctrl_t         run_ctrl_s;
  haz_ctrl_t         ctrl_s;
  haz_ctrl_t         ctrl_out_s;

  assign mem_pend_s = (ex_mem_memread | ex_mem_memwrite) & ~dmem_ack;
  assign load_use_s = load_use_hit(id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2);

  // Free-flowing priority: redirect squashes the dependent instruction, so it beats load-use.
  always_comb begin
    run_ctrl_s = CTRL_NONE;
    if (ex_redirect) begin
      run_ctrl_s = CTRL_REDIRECT;
    end else if (load_use_s) begin
      run_ctrl_s = CTRL_LOAD_USE;
    end else begin
      run_ctrl_s = CTRL_NONE;
    end
  end

  // Mealy control and next-state: freeze while memory is pending, watchdog on wait length.
  always_comb begin
    ctrl_s    = CTRL_NONE;
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        if (mem_pend_s) begin
          ctrl_s  = CTRL_FREEZE;
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else begin
          ctrl_s  = run_ctrl_s;
          state_d = RUN;
          wcnt_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_pend_s) begin
          ctrl_s = CTRL_FREEZE;
          if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end else begin
          // Ack arrived: behave as RUN this cycle, so a latched redirect fires now.
          ctrl_s  = run_ctrl_s;
          state_d = RUN;
          wcnt_d  = '0;
        end
      end
      TIMEOUT: begin
        ctrl_s    = CTRL_FREEZE;
        state_d   = TIMEOUT;
        timeout_d = 1'b1;
      end
      default: begin
        ctrl_s    = CTRL_NONE;
        state_d   = RUN;
        wcnt_d    = '0;
        timeout_d = 1'b0;
      end
    endcase
  end

  // Strobes are held inactive for as long as reset is asserted.
  always_comb begin
    ctrl_out_s = CTRL_NONE;
    if (reset) begin
      ctrl_out_s = CTRL_NONE;
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  // State, wait counter and sticky watchdog flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign pc_stall      = ctrl_out_s.pc_stall;
  assign if_id_stall   = ctrl_out_s.if_id_stall;
  assign id_ex_stall   = ctrl_out_s.id_ex_stall;
  assign ex_mem_stall  = ctrl_out_s.ex_mem_stall;
  assign if_id_flush   = ctrl_out_s.if_id_flush;
  assign id_ex_flush   = ctrl_out_s.id_ex_flush;
  assign mem_wb_bubble = ctrl_out_s.mem_wb_bubble;
  assign dmem_timeout  = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl_out_s.pc_stall),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl_out_s.if_id_flush),
    .count (flush_count)
  );

endmodule
